// File: rtl/display_pkg.sv
// Seven-segment constants and helpers shared by the display scanner.
// Latency: none (constants and pure functions).
// Backpressure: not applicable.
package display_pkg;

  // Bit positions within the 8-bit segment byte
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // All segments and dp unlit, expressed active-high
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high g..a pattern for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Maps an active-high byte onto the board pin polarity
  function automatic logic [7:0] seg_polarity(input logic [7:0] seg_hi,
                                              input logic act_low);
    return act_low ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/display_scan_n_seg7_decode.sv
// Nibble + decimal point + dark flag to one segment byte at pin polarity.
// Latency: purely combinational.
// Backpressure: none.
module seg7_decode
  import display_pkg::*;
#(
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] seg
);

  logic [7:0] seg_hi;

  always_comb begin
    seg_hi = SEG_BLANK;
    if (!dark) begin
      seg_hi[SEG_G:SEG_A] = hex_to_seg(nibble);
      seg_hi[SEG_DP]      = dp;
    end
  end

  assign seg = seg_polarity(seg_hi, SEG_ACT_LOW);

endmodule

// File: rtl/display_scan_n.sv
// Multiplexed hex display scanner with double buffer, blanking, LZ suppression and PWM.
// Latency: seg/digit are combinational from registered state; a load shows from the next frame.
// Backpressure: none; load always accepted, later loads overwrite the pending buffer.
module display_scan_n
  import display_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int DIV_W       = 15,
  parameter int BRIGHT_W    = 3,
  parameter int SEG_ACT_LOW = 1,
  localparam int SEL_W      = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [SEL_W-1:0]      which,
  output logic [7:0]            seg,
  output logic [3:0]            digit,
  output logic [DIV_W-1:0]      count,
  output logic                  frame_tick
);

  logic [4*DIGITS-1:0] act_data, pend_data;
  logic [DIGITS-1:0]   act_dp, pend_dp;
  logic [DIGITS-1:0]   act_blank, pend_blank;
  logic                pend_vld;

  logic slot_end;
  logic last_digit;
  logic boundary;

  assign slot_end   = &count;
  assign last_digit = (which == SEL_W'(DIGITS - 1));
  assign boundary   = slot_end && last_digit;

  // Prescaler, scan index and frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      which      <= '0;
      frame_tick <= 1'b0;
    end else begin
      count      <= count + 1'b1;
      frame_tick <= boundary;
      if (slot_end) begin
        which <= last_digit ? '0 : which + 1'b1;
      end
    end
  end

  // Pending is promoted only at the frame boundary so a frame never mixes two loads;
  // a load on that same edge reads the old pending here and stays queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_vld   <= 1'b0;
    end else begin
      if (boundary && pend_vld) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (load) begin
        pend_data  <= data;
        pend_dp    <= dp;
        pend_blank <= blank_mask;
        pend_vld   <= 1'b1;
      end else if (boundary) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // True when every active nibble from the current index upward is zero
  logic upper_zero;
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(which) && act_data[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
  end

  logic pwm_on;
  logic lz_dark;
  logic dark;

  assign digit   = act_data[{which, 2'b00} +: 4];
  assign pwm_on  = (count[DIV_W-1 -: BRIGHT_W] <= bright);
  assign lz_dark = lz_en && (which != '0) && upper_zero;
  assign dark    = act_blank[which] || lz_dark || !pwm_on;

  seg7_decode #(
    .SEG_ACT_LOW (SEG_ACT_LOW != 0)
  ) u_decode (
    .nibble (digit),
    .dp     (act_dp[which]),
    .dark   (dark),
    .seg    (seg)
  );

endmodule

// File: doc/display_scan_n.md
Name: display_scan_n

Overview:
Parametrised successor to the 8-digit multiplexed hex display driver. It time-multiplexes DIGITS hex nibbles onto one 8-bit segment bus plus a binary digit-select index. It adds per-digit decimal points, per-digit blanking, leading-zero suppression, PWM brightness and tear-free double-buffered loading. It sits between CPU/debug registers and board seven-segment pins.

Parameters:
DIGITS, 8, number of multiplexed digits (2..16)
DIV_W, 15, width of the refresh prescaler; one digit slot = 2**DIV_W clocks
BRIGHT_W, 3, width of the brightness control (2..DIV_W)
SEG_ACT_LOW, 1, 1 = segments and dp active-low (lit = 0); 0 = active-high
SEL_W, $clog2(DIGITS), width of the digit index (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
data  in  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 = least significant)
dp  in  DIGITS  decimal point per digit, 1 = lit
blank_mask  in  DIGITS  1 = force digit dark
load  in  1  single-cycle strobe; captures data/dp/blank_mask into the pending buffer
lz_en  in  1  leading-zero suppression enable (live, not latched)
bright  in  BRIGHT_W  brightness level; all-ones = 100% duty (live)
which  out  SEL_W  index of the digit currently driven
seg  out  8  seg[6:0] = g,f,e,d,c,b,a; seg[7] = dp
digit  out  4  nibble currently displayed (debug)
count  out  DIV_W  prescaler value (debug)
frame_tick  out  1  one-cycle pulse when which wraps DIGITS-1 -> 0

Behaviour:
- Reset values: count=0, which=0, active buffer=0, pending buffer=0, pending_valid=0, frame_tick=0, digit=0. seg equals the pattern for "0" on digit 0 (8'hC0 when SEG_ACT_LOW=1).
- count increments every clk and wraps at 2**DIV_W-1. On the wrap cycle, which advances by 1 and wraps from DIGITS-1 to 0 (DIGITS need not be a power of two).
- frame_tick is registered. It is high for exactly the cycle in which which==0 after a wrap from DIGITS-1.
- load copies data, dp and blank_mask to the pending buffer and sets pending_valid. A later load before the frame boundary overwrites the pending buffer.
- At the frame boundary (the same edge on which which becomes 0), if pending_valid is set, pending is copied to active and pending_valid is cleared. If load coincides with the boundary edge, the old pending goes to active and the new values stay pending for the next frame. A frame is never torn.
- digit = active nibble[which]. seg is combinational from registered state (active, which, count, lz_en, bright) and is valid in the same cycle as which; there is no added latency.
- Digit i is dark when any of these holds:
  - blank_mask[i] is set;
  - lz_en=1, i>0, and active nibbles DIGITS-1..i are all zero (digit 0 is never zero-suppressed);
  - the PWM condition is off.
- Dark means all 8 bits are unlit, dp included (8'hFF when active-low).
- PWM: lit only when count[DIV_W-1 -: BRIGHT_W] <= bright. bright=0 gives 1/2**BRIGHT_W duty; all-ones gives 100%.
- Hex encoding (active-high g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. seg[7]=dp. The whole byte is inverted when SEG_ACT_LOW=1.
- Asynchronous reset mid-frame immediately forces all reset values. Any pending load is discarded.

Decomposition:
- display_pkg: hex-to-segment constant table, SEG_BLANK constant, seg bit-ordering localparams, helper function for active-low inversion.
- Sub-module seg7_decode: combinational nibble+dp+dark -> 8-bit seg, parametrised by SEG_ACT_LOW.
- Prescaler, scan index, double buffer and LZ/PWM logic live in display_scan_n.

Test Plan:
(DIGITS=8, DIV_W=4, BRIGHT_W=2, bright=3 unless stated)
1. Reset: assert rst_n=0 mid-run -> which=0, count=0, frame_tick=0, seg=8'hC0 in the same cycle, without waiting for a clock edge.
2. Double buffer: load 32'hFEDCBA98 while which=3 -> digits 3..7 keep old values until frame_tick. On the first slot with which=7 after the boundary, digit=4'hF and seg=8'h8E.
3. Leading-zero suppression: load 32'h00000120 with lz_en=1 -> digits 7..3 seg=8'hFF; digit 2 seg=8'hF9; digit 1 seg=8'hA4; digit 0 seg=8'hC0. With lz_en=0, digits 7..3 show 8'hC0.
4. Brightness: bright=1 -> in each 16-cycle slot, seg is lit for count 0..7 and is 8'hFF for count 8..15. bright=3 -> lit all 16 cycles.
5. dp and blank: load dp=8'h01, blank_mask=8'h80, data=32'h76543210 -> digit 0 seg=8'h40, digit 7 seg=8'hFF.
6. Boundary collision: pulse load with data A one slot before the boundary, then load with data B on the boundary edge -> frame N+1 shows A, frame N+2 shows B, and frame_tick occurs once per 128 cycles.
